// File: rtl/display_word_serializer_pkg.sv
// Shared types and widths for the display record read path.
// Records are split into a low word and a zero-padded high word.
package display_word_serializer_pkg;

    localparam int DISPLAY_REC_W  = 59;
    localparam int DISPLAY_WORD_W = 32;

    typedef logic [DISPLAY_REC_W-1:0] display_rec_t;

    typedef enum logic {
        LO = 1'b0,
        HI = 1'b1
    } phase_t;

endpackage

// File: rtl/display_rec_fifo.sv
// Record storage for the display serializer: DEPTH x DATA_W circular buffer
// with registered pointers and occupancy count; pushes into a full buffer are ignored.
module display_rec_fifo
#(
    parameter int DATA_W = 59,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              wr_en_s;
    logic              rd_en_s;

    assign full    = (count_r == CNT_W'(DEPTH));
    assign empty   = (count_r == CNT_W'(0));
    assign count   = count_r;
    assign head    = mem_r[rd_ptr_r];
    assign wr_en_s = push & ~full;
    assign rd_en_s = pop & ~empty;

    // Storage array, pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/display_word_serializer.sv
// Buffers display records and drains each one as two WORD_W words (low first)
// over a valid/ready stream; drops and flags pushes that arrive while full.
module display_word_serializer
    import display_word_serializer_pkg::*;
#(
    parameter int DATA_W = DISPLAY_REC_W,
    parameter int WORD_W = DISPLAY_WORD_W,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              ld_en_display,
    input  logic [DATA_W-1:0] display_value,
    output logic              in_ready,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              word_last,
    input  logic              word_ready,
    output logic              overflow,
    output logic [CNT_W-1:0]  rec_count
);

    phase_t            phase_r;
    logic              overflow_r;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic              handshake_s;
    logic [DATA_W-1:0] head_s;
    logic [WORD_W-1:0] word_s;

    // in_ready comes from the registered count only, so a push while full is dropped
    // even when the head record finishes in the same cycle.
    assign push_s      = ld_en_display & ~full_s;
    assign handshake_s = ~empty_s & word_ready;
    assign pop_s       = handshake_s & (phase_r == HI);

    display_rec_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .push_data (display_value),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (rec_count)
    );

    // Phase FSM: each handshake alternates between the low and high word of the head record.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_r <= LO;
        end else if (handshake_s) begin
            case (phase_r)
                LO:      phase_r <= HI;
                HI:      phase_r <= LO;
                default: phase_r <= LO;
            endcase
        end else begin
            phase_r <= phase_r;
        end
    end

    // Sticky drop flag; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (ld_en_display & full_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Word select: high word is the record's upper bits zero-extended to WORD_W.
    always_comb begin
        word_s = '0;
        case (phase_r)
            LO:      word_s = head_s[WORD_W-1:0];
            HI:      word_s[DATA_W-WORD_W-1:0] = head_s[DATA_W-1:WORD_W];
            default: word_s = '0;
        endcase
    end

    assign word_out   = word_s;
    assign word_last  = (phase_r == HI);
    assign word_valid = ~empty_s;
    assign in_ready   = ~full_s;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_display_word_serializer.sv
// Directed plus random bench for display_word_serializer: expected words are queued
// when records are accepted and compared as the stream hands them out.
module tb_display_word_serializer;
    import display_word_serializer_pkg::*;

    localparam int DATA_W = DISPLAY_REC_W;
    localparam int WORD_W = DISPLAY_WORD_W;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clock;
    logic              reset;
    logic              ld_en_display;
    logic [DATA_W-1:0] display_value;
    logic              in_ready;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_last;
    logic              word_ready;
    logic              overflow;
    logic [CNT_W-1:0]  rec_count;

    display_word_serializer #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ld_en_display (ld_en_display),
        .display_value (display_value),
        .in_ready      (in_ready),
        .word_out      (word_out),
        .word_valid    (word_valid),
        .word_last     (word_last),
        .word_ready    (word_ready),
        .overflow      (overflow),
        .rec_count     (rec_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int              n_cmp = 0;
    int              n_fail = 0;
    logic [32:0]     exp_q[$];
    int              m_cnt = 0;
    logic            m_phase = 1'b0;
    logic            m_ovf = 1'b0;
    logic            stall_prev = 1'b0;
    logic [32:0]     stall_word = 33'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check the visible word, step the model, then check state.
    task automatic cycle(input logic rst, input logic push, input logic [DATA_W-1:0] val,
                         input logic rdy);
        logic acc;
        logic hs;
        logic pop_rec;
        reset = rst; ld_en_display = push; display_value = val; word_ready = rdy;
        #1;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            chk("word_valid", word_valid, m_cnt != 0);
            chk("in_ready", in_ready, m_cnt != DEPTH);
            if (m_cnt != 0 && exp_q.size() > 0) begin
                chk("word_out", word_out, exp_q[0][31:0]);
                chk("word_last", word_last, exp_q[0][32]);
                if (stall_prev) chk("stall_hold", {word_last, word_out}, stall_word);
            end
            hs = (m_cnt != 0) && rdy;
            stall_prev = (m_cnt != 0) && !rdy;
            stall_word = {word_last, word_out};
            acc = push && (m_cnt != DEPTH);
            pop_rec = hs && m_phase;
            if (hs) begin
                void'(exp_q.pop_front());
                m_phase = ~m_phase;
            end
            if (acc) begin
                exp_q.push_back({1'b0, val[31:0]});
                exp_q.push_back({1'b1, 5'd0, val[58:32]});
            end
            if (push && !acc) m_ovf = 1'b1;
            m_cnt = m_cnt + (acc ? 1 : 0) - (pop_rec ? 1 : 0);
        end
        @(posedge clock);
        @(negedge clock);
        if (rst) begin
            exp_q.delete();
            m_cnt = 0; m_phase = 1'b0; m_ovf = 1'b0;
        end
        chk("rec_count", rec_count, m_cnt);
        chk("overflow", overflow, m_ovf);
    endtask

    function automatic logic [DATA_W-1:0] rec_of(input int k);
        logic [63:0] v;
        v = {32'hA5000000 ^ 32'(k * 7), 32'h1000 + 32'(k)};
        return v[DATA_W-1:0];
    endfunction

    initial begin
        logic [DATA_W-1:0] r;
        reset = 1'b1; ld_en_display = 1'b0; display_value = '0; word_ready = 1'b0;
        @(negedge clock);
        cycle(1'b1, 1'b0, '0, 1'b0);
        chk("rst_word_out", word_out, 32'd0);
        chk("rst_word_last", word_last, 1'b0);
        chk("rst_word_valid", word_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_rec_count", rec_count, 3'd0);

        // single record straight through
        r = 59'h7FF_FFFF_1234_5678;
        cycle(1'b0, 1'b1, r, 1'b1);
        chk("t1_lo", word_out, 32'h1234_5678);
        chk("t1_lo_last", word_last, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("t1_hi", word_out, 32'h07FF_FFFF);
        chk("t1_hi_last", word_last, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("t1_empty", word_valid, 1'b0);

        // fill, overflow, drain
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, rec_of(k), 1'b0);
        chk("t2_full_ready", in_ready, 1'b0);
        chk("t2_full_count", rec_count, 3'd4);
        cycle(1'b0, 1'b1, 59'h123, 1'b0);
        chk("t2_overflow", overflow, 1'b1);
        for (int k = 0; k < 9; k++) cycle(1'b0, 1'b0, '0, 1'b1);
        chk("t2_drained", word_valid, 1'b0);

        // stalls mid-record
        cycle(1'b0, 1'b1, rec_of(10), 1'b0);
        cycle(1'b0, 1'b1, rec_of(11), 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, '0, 1'b1);

        // full FIFO: push coincides with final high-word handshake
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, rec_of(20 + k), 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, rec_of(99), 1'b1);
        chk("t4_count", rec_count, 3'd3);
        chk("t4_overflow", overflow, 1'b1);

        // steady state at 3 records across pointer wrap
        for (int k = 0; k < 24; k++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            cycle(1'b0, 1'b1, rec_of(40 + k), 1'b1);
            chk("t5_count", rec_count, 3'd3);
        end
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, '0, 1'b1);

        // reset while sending the high word of record 2 of 3
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, rec_of(70 + k), 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("t6_in_hi", word_last, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        chk("t6_valid", word_valid, 1'b0);
        chk("t6_count", rec_count, 3'd0);
        chk("t6_overflow", overflow, 1'b0);
        r = 59'h123_4567_89AB_CDEF;
        cycle(1'b0, 1'b1, r, 1'b0);
        chk("t6_new_lo", word_out, 32'h89AB_CDEF);
        chk("t6_new_last", word_last, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);

        // random traffic
        for (int k = 0; k < 10000; k++) begin
            r = DATA_W'({$urandom, $urandom});
            cycle(1'b0, ($urandom_range(0, 99) < 45), r, ($urandom_range(0, 99) < 60));
        end
        for (int k = 0; k < 12; k++) cycle(1'b0, 1'b0, '0, 1'b1);
        chk("final_empty", word_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
